hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_MAX_CYC, default 64, giving the maximum number of cycles spent in MDU_WAIT before timeout.
REQ-002 SHALL have port sys_clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have ports id_valid, id_use_rs1, id_use_rs2, id_is_mdu  in  1 each; ID-stage instruction valid, source-register usage flags, and multi-cycle op flag.
REQ-005 SHALL have ports id_rs1, id_rs2  in  5 each; ID-stage source register indices.
REQ-006 SHALL have ports ex_valid, ex_is_load  in  1 each, and ex_rd  in  5; describe the instruction currently in the ID/EX register.
REQ-007 SHALL have port ex_redirect  in  1; a taken branch or jump was resolved in EX this cycle.
REQ-008 SHALL have port mdu_done  in  1; the multi-cycle unit's result is valid this cycle.
REQ-009 SHALL have ports pc_stall, if_id_stall, if_id_flush, id_ex_bubble, mdu_start  out  1 each.
REQ-010 SHALL have port state  out  2; current FSM state (RUN=0, MDU_WAIT=1).
REQ-011 SHALL have port mdu_timeout  out  1; sticky error flag.

Function
REQ-012 SHALL define load_use = id_valid & ex_valid & ex_is_load & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-013 SHALL drive all 1-bit outputs combinationally from state and inputs; no registered outputs except state, mdu_timeout and the counters.
REQ-014 In RUN, SHALL give ex_redirect highest priority: if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0, mdu_start=0, state stays RUN.
REQ-015 In RUN without redirect, when load_use=1, SHALL assert pc_stall=1, if_id_stall=1 and id_ex_bubble=1 for exactly that cycle, and SHALL NOT start the MDU.
REQ-016 In RUN without redirect or load_use, when id_valid & id_is_mdu, SHALL pulse mdu_start=1 for one cycle, assert all three stalls, clear the cycle counter and enter MDU_WAIT.
REQ-017 In MDU_WAIT with mdu_done=0, SHALL assert pc_stall, if_id_stall and id_ex_bubble, increment the cycle counter, and ignore ex_redirect and load_use.
REQ-018 In MDU_WAIT with mdu_done=1, SHALL deassert all stalls in that same cycle, so the MDU instruction advances, and return to RUN; mdu_start SHALL NOT re-pulse for that instruction.
REQ-019 When the counter reaches MDU_MAX_CYC-1 in MDU_WAIT without mdu_done, SHALL set mdu_timeout, deassert stalls that cycle and return to RUN.
REQ-020 SHALL treat mdu_done outside MDU_WAIT as a no-op.
REQ-021 SHALL assert no stall, flush or bubble when id_valid=0, except for redirect and MDU_WAIT behaviour.
REQ-022 SHALL size the counter as clog2(MDU_MAX_CYC) bits and SHALL NOT let it wrap.

Reset
REQ-023 While sys_rst=1, SHALL force state=RUN, counter=0, mdu_timeout=0 and performance counters=0, and hold all combinational outputs at 0.
REQ-024 SHALL honour reset asserted mid-MDU_WAIT: the next cycle is RUN with no stalls and no mdu_start.

Configuration
REQ-025 SHALL compile 32-bit performance counters stall_cnt and flush_cnt (out, 32 each) only when HAZARD_PERF_CNT_EN is defined; they count cycles with pc_stall=1 and with if_id_flush=1 respectively, saturating at 0xFFFFFFFF.
REQ-026 Without HAZARD_PERF_CNT_EN, these ports and their registers SHALL NOT exist; all other behaviour is identical.

Verification
REQ-027 ex_valid=1, ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> exactly one cycle of pc_stall, if_id_stall and id_ex_bubble, then 0.
REQ-028 Same as REQ-027 but ex_rd=0 -> no stall.
REQ-029 Load-use and ex_redirect asserted in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_stall=0.
REQ-030 id_is_mdu=1 with mdu_done raised 5 cycles later -> mdu_start pulses once, 5 stall cycles, stalls drop in the mdu_done cycle, state returns to 0.
REQ-031 MDU_MAX_CYC=8 with mdu_done never raised -> mdu_timeout=1 after 8 cycles in MDU_WAIT and stays set until reset.
REQ-032 sys_rst pulsed in the third MDU_WAIT cycle -> state=0, all outputs 0; with HAZARD_PERF_CNT_EN, stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and multi-cycle MDU waits.
// Optional 32-bit stall/flush performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned MDU_MAX_CYC = 64
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       id_valid,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_is_mdu,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic       ex_redirect,
  input  logic       mdu_done,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       mdu_start,
  output logic [1:0] state,
  output logic       mdu_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int unsigned CntW = (MDU_MAX_CYC > 1) ? $clog2(MDU_MAX_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MDU_MAX_CYC - 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMduWait = 2'd1
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            load_use;

  assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    mdu_start    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (ex_redirect) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (id_valid && id_is_mdu) begin
          mdu_start    = 1'b1;
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
          cnt_d        = '0;
          state_d      = StMduWait;
        end
      end
      StMduWait: begin
        // Releasing stalls on done lets the MDU instruction advance this same cycle.
        if (mdu_done) begin
          state_d = StRun;
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          state_d   = StRun;
        end else begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q + CntW'(1);
        end
      end
      default: state_d = StRun;
    endcase

    if (sys_rst) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      mdu_start    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign state       = state_q;
  assign mdu_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl, built with MDU_MAX_CYC=8.
module tb_hazard_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_is_mdu;
  logic [4:0] id_rs1, id_rs2;
  logic       ex_valid, ex_is_load;
  logic [4:0] ex_rd;
  logic       ex_redirect, mdu_done;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_bubble, mdu_start;
  logic [1:0] state;
  logic       mdu_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  logic [4:0] outs;

  int checks   = 0;
  int failures = 0;
  int n_stall, n_start;

  hazard_ctrl #(.MDU_MAX_CYC(8)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .id_valid     (id_valid),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_is_mdu    (id_is_mdu),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .mdu_done     (mdu_done),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .mdu_start    (mdu_start),
    .state        (state),
    .mdu_timeout  (mdu_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, mdu_start}
  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, mdu_start};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_mdu = 0;
    id_rs1 = 0; id_rs2 = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0;
    ex_redirect = 0; mdu_done = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    id_valid = 1; id_use_rs1 = 1; id_rs1 = rd;
    ex_valid = 1; ex_is_load = 1; ex_rd = rd;
  endtask

  initial begin
    idle();
    // Reset with aggressive inputs: all outputs must stay low.
    sys_rst = 1; id_valid = 1; id_is_mdu = 1; ex_redirect = 1;
    tick(); tick();
    settle();
    check_eq("rst_outs", outs, 5'b00000);
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_timeout", mdu_timeout, 1'b0);
    idle();
    tick();
    sys_rst = 0;
    settle();
    check_eq("idle_outs", outs, 5'b00000);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("rst_stall_cnt", stall_cnt, 32'd0);
`endif

    // Load-use on rs1: one stall cycle, then the bubble clears EX.
    set_load_use(5'd5);
    settle();
    check_eq("lu_rs1", outs, 5'b11010);
    tick();
    ex_valid = 0; ex_is_load = 0;
    settle();
    check_eq("lu_after", outs, 5'b00000);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("stall_cnt_one", stall_cnt, 32'd1);
`endif

    // Load-use on rs2.
    idle();
    id_valid = 1; id_use_rs2 = 1; id_rs2 = 5'd7;
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd7;
    settle();
    check_eq("lu_rs2", outs, 5'b11010);

    // Matching index but the operand is unused.
    id_use_rs2 = 0;
    settle();
    check_eq("lu_unused", outs, 5'b00000);

    // x0 never hazards.
    idle();
    set_load_use(5'd0);
    settle();
    check_eq("lu_x0", outs, 5'b00000);

    // No hazard when ID is not valid.
    set_load_use(5'd9);
    id_valid = 0;
    settle();
    check_eq("lu_id_invalid", outs, 5'b00000);

    // Redirect wins over load-use.
    id_valid = 1;
    ex_redirect = 1;
    settle();
    check_eq("redirect_lu", outs, 5'b00110);

    // Redirect alone, ID invalid.
    idle();
    ex_redirect = 1;
    settle();
    check_eq("redirect_only", outs, 5'b00110);

    // Load-use beats MDU start.
    idle();
    set_load_use(5'd3);
    id_is_mdu = 1;
    settle();
    check_eq("lu_over_mdu", outs, 5'b11010);

    // mdu_done in RUN is ignored.
    idle();
    mdu_done = 1;
    settle();
    check_eq("done_in_run", outs, 5'b00000);
    tick();
    check_eq("done_in_run_state", state, 2'd0);

    // MDU op completing 5 cycles after issue.
    idle();
    id_valid = 1; id_is_mdu = 1;
    n_stall = 0; n_start = 0;
    settle();
    check_eq("mdu_issue", outs, 5'b11011);
    n_stall += int'(pc_stall); n_start += int'(mdu_start);
    for (int i = 1; i < 5; i++) begin
      tick();
      ex_redirect = (i == 2);
      settle();
      check_eq("mdu_wait_outs", outs, 5'b11010);
      n_stall += int'(pc_stall); n_start += int'(mdu_start);
    end
    check_eq("mdu_wait_state", state, 2'd1);
    tick();
    ex_redirect = 0;
    mdu_done = 1;
    settle();
    check_eq("mdu_done_outs", outs, 5'b00000);
    check_eq("mdu_stall_cycles", n_stall, 5);
    check_eq("mdu_start_pulses", n_start, 1);
    tick();
    idle();
    settle();
    check_eq("mdu_back_run", state, 2'd0);
    check_eq("mdu_no_timeout", mdu_timeout, 1'b0);

    // Timeout: MDU_MAX_CYC=8, done never arrives.
    id_valid = 1; id_is_mdu = 1;
    settle();
    check_eq("to_issue", outs, 5'b11011);
    for (int i = 0; i < 7; i++) begin
      tick();
      settle();
      check_eq("to_wait_outs", outs, 5'b11010);
    end
    tick();
    settle();
    check_eq("to_last_outs", outs, 5'b00000);
    check_eq("to_last_state", state, 2'd1);
    check_eq("to_not_yet", mdu_timeout, 1'b0);
    idle();
    tick();
    check_eq("to_state", state, 2'd0);
    check_eq("to_set", mdu_timeout, 1'b1);
    tick(); tick(); tick();
    check_eq("to_sticky", mdu_timeout, 1'b1);

    // Reset in the third MDU_WAIT cycle.
    id_valid = 1; id_is_mdu = 1;
    tick(); tick(); tick();
    settle();
    check_eq("rmid_wait_state", state, 2'd1);
    sys_rst = 1;
    settle();
    check_eq("rmid_outs", outs, 5'b00000);
    idle();
    tick();
    check_eq("rmid_state", state, 2'd0);
    check_eq("rmid_timeout_clr", mdu_timeout, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("rmid_stall_cnt", stall_cnt, 32'd0);
`endif
    sys_rst = 0;
    settle();
    check_eq("rmid_release_outs", outs, 5'b00000);
    tick();
    check_eq("rmid_release_state", state, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
